mcu0_fetch: RTL and testbench
=============================

# mcu0_fetch

Instruction fetch unit for the 16-bit accumulator MCU. Reads big-endian 16-bit instructions as two byte reads from a byte-wide synchronous instruction memory, buffers up to DEPTH complete instructions, and presents them to the decode/execute stage with a valid/ready handshake. It sits directly upstream of the controller/ALU datapath and replaces the combinational PC+2 / IM path. A redirect input from execute (JMP, taken JEQ) flushes the fetch stream.

## Interface
- W, 16: data/address width (bits).
- DEPTH, 2: instruction buffer entries (≥2).
- RESET_PC, 16'h0000: first fetch address after reset (even).

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- mem_rd  out  1  byte read strobe.
- mem_addr  out  W  byte address, valid when mem_rd=1.
- mem_rdata  in  8  read data, valid the cycle after mem_rd.
- ir  out  W  instruction word, {byte@pc, byte@pc+1}.
- ir_pc  out  W  byte address of ir.
- ir_valid  out  1  buffer head holds an instruction.
- ir_ready  in  1  consumer accepts head this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  W  new fetch address; bit 0 ignored (treated as 0).

## Operation
- Registers: fpc (next HI address), FSM state, hi_byte latch, return-tag pipe (valid, is_lo, 1 stage), buffer of DEPTH {ir, ir_pc} entries, occupancy count 0..DEPTH, inflight (0/1).
- FSM states: HI (issue HI read), LO (issue LO read), STALL (no issue).
  - HI: if count+inflight < DEPTH → mem_rd=1, mem_addr=fpc, inflight set, go LO; else go STALL without reading.
  - LO: mem_rd=1, mem_addr=fpc+1, fpc += 2 (mod 2^W), go HI.
  - STALL: mem_rd=0; go HI when count+inflight < DEPTH.
- Return path: tagged HI data latched into hi_byte; tagged LO data completes {hi_byte, mem_rdata}, pushed with its pc at end of that cycle, inflight cleared.
- Credit check uses registered count (same-cycle pop not credited) → buffer never overflows; no push is ever dropped.
- Pop: ir_valid && ir_ready; push and pop in same cycle leave count unchanged.
- Redirect (highest priority): at end of cycle, buffer emptied, count=0, inflight=0, return tags cleared (any data returning next cycle is discarded), fpc={redirect_pc[W-1:1],0}, state=HI. A handshake completing in the redirect cycle is still a valid accept. mem_rd in the redirect cycle may assert; its data is discarded.
- Wrap: fpc 0xFFFE → LO at 0xFFFF → fpc 0x0000.
- Reset: fpc=RESET_PC, state=HI, count=0, inflight=0, tags cleared; outputs ir=0, ir_pc=0, ir_valid=0, mem_rd=0, mem_addr=0 during reset cycle. Reset mid-fetch discards all in-flight data.

## Timing
- Cycle 0 = first cycle with reset=0: HI read RESET_PC; cycle 1 LO read; cycle 2 LO data; ir_valid=1 from cycle 3.
- Redirect in cycle t: ir_valid=0 in t+1..t+3, HI read of new pc in t+1, first new ir_valid in t+4.
- Sustained throughput: 1 instruction / 2 cycles when ir_ready=1.
- ir/ir_pc/ir_valid driven from registers; mem_rd/mem_addr decoded from registered state only (no input-to-output combinational path).

## Structure
- Shared package mcu0_pkg: W, fetch state enum (HI, LO, STALL), RESET_PC default, opcode constants shared with controller.
- Sub-module mcu0_ibuf: DEPTH-entry synchronous FIFO of {ir, ir_pc} with push/pop/flush, count output.

## Test plan
- Memory 00:01 0A 10 0C, ir_ready=1 from reset → cycle 3 ir=0x010A ir_pc=0; cycle 5 ir=0x100C ir_pc=2.
- ir_ready=0 held → exactly 2 instructions buffered, mem_rd stays 0 in STALL; release → 0x010A then 0x100C, no loss or duplicate.
- Redirect to 0x0011 in cycle 6 → fetch restarts at 0x0010, ir_valid=0 in 7..9, cycle 10 ir_pc=0x0010; stale data discarded.
- Redirect in the same cycle as a push and a pop → count=0 next cycle, popped instruction counted once.
- redirect_pc=0xFFFE → ir_pc 0xFFFE then 0x0000, bytes at FFFE/FFFF/0000/0001.
- Reset asserted mid-LO with data in flight → next cycle all outputs 0, restart at RESET_PC, old byte never appears in ir.

Source files
------------

// File: rtl/mcu0_pkg.sv
// Shared definitions for the 16-bit accumulator MCU: widths, fetch FSM states
// and the opcode map the controller decodes.
package mcu0_pkg;
  localparam int MCU_W = 16;
  localparam logic [MCU_W-1:0] MCU_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_HI    = 2'd0,
    ST_LO    = 2'd1,
    ST_STALL = 2'd2
  } fetch_st_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JEQ = 4'h5;
  localparam logic [3:0] OP_NOP = 4'hF;
endpackage

// File: rtl/mcu0_ibuf.sv
// Shift-style instruction FIFO: entry 0 is always the head, so the consumer
// sees a register output; flush and reset empty it in one cycle.
module mcu0_ibuf #(
  parameter int EW    = 32,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [EW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [EW-1:0] o_head,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);
  logic [DEPTH-1:0][EW-1:0] r_ent, w_nxt;
  logic [CW-1:0]            r_cnt, w_wr_idx;
  logic                     w_pop;

  assign w_pop    = i_pop && (r_cnt != '0);
  // A same-cycle pop shifts everything down, so the push lands one slot lower.
  assign w_wr_idx = r_cnt - CW'(w_pop);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [EW-1:0] w_up;
    if (g < DEPTH-1) begin : g_mid
      assign w_up = r_ent[g+1];
    end else begin : g_top
      assign w_up = '0;
    end
    assign w_nxt[g] = (i_push && w_wr_idx == CW'(g)) ? i_push_data :
                      w_pop                          ? w_up        : r_ent[g];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_ent <= '0;
      r_cnt <= '0;
    end else begin
      r_ent <= w_nxt;
      r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
    end
  end

  assign o_head  = r_ent[0];
  assign o_valid = (r_cnt != '0);
  assign o_count = r_cnt;
endmodule

// File: rtl/mcu0_fetch.sv
// Instruction fetch: two byte reads per big-endian instruction, credit-gated
// so the buffer can never overflow, with redirect flushing the stream.
module mcu0_fetch
  import mcu0_pkg::*;
#(
  parameter int          W        = MCU_W,
  parameter int          DEPTH    = 2,
  parameter logic [W-1:0] RESET_PC = W'(MCU_RESET_PC)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  output logic         o_mem_rd,
  output logic [W-1:0] o_mem_addr,
  input  logic [7:0]   i_mem_rdata,
  output logic [W-1:0] o_ir,
  output logic [W-1:0] o_ir_pc,
  output logic         o_ir_valid,
  input  logic         i_ir_ready,
  input  logic         i_redirect,
  input  logic [W-1:0] i_redirect_pc
);
  localparam int CW = $clog2(DEPTH+1);

  fetch_st_e      r_st, w_st_nxt;
  logic [W-1:0]   r_fpc, r_tag_pc, w_addr;
  logic [7:0]     r_hi;
  logic           r_tag_vld, r_tag_lo, r_inflight;
  logic           w_issue, w_credit, w_push, w_pop, w_valid;
  logic [CW-1:0]  w_count;
  logic [2*W-1:0] w_head;

  // Registered count only: a pop in this cycle is not credited until next.
  assign w_credit = (int'(w_count) + int'(r_inflight)) < DEPTH;

  always_comb begin
    w_st_nxt = r_st;
    w_issue  = 1'b0;
    w_addr   = '0;
    case (r_st)
      ST_HI: begin
        if (w_credit) begin
          w_issue  = 1'b1;
          w_addr   = r_fpc;
          w_st_nxt = ST_LO;
        end else begin
          w_st_nxt = ST_STALL;
        end
      end
      ST_LO: begin
        w_issue  = 1'b1;
        w_addr   = r_fpc | W'(1);
        w_st_nxt = ST_HI;
      end
      ST_STALL: if (w_credit) w_st_nxt = ST_HI;
      default:  w_st_nxt = ST_HI;
    endcase
  end

  // Reset masks the strobe so nothing is read while the unit is held.
  assign o_mem_rd   = w_issue && !i_reset;
  assign o_mem_addr = o_mem_rd ? w_addr : '0;

  assign w_push = r_tag_vld && r_tag_lo;
  assign w_pop  = w_valid && i_ir_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_st       <= ST_HI;
      r_fpc      <= RESET_PC;
      r_tag_vld  <= 1'b0;
      r_tag_lo   <= 1'b0;
      r_tag_pc   <= '0;
      r_hi       <= '0;
      r_inflight <= 1'b0;
    end else if (i_redirect) begin
      r_st       <= ST_HI;
      r_fpc      <= i_redirect_pc & ~W'(1);
      r_tag_vld  <= 1'b0;
      r_tag_lo   <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_tag_vld <= w_issue;
      r_tag_lo  <= (r_st == ST_LO);
      if (r_st == ST_LO) begin
        r_fpc    <= r_fpc + W'(2);
        r_tag_pc <= r_fpc;
      end
      if (r_tag_vld && !r_tag_lo) r_hi <= i_mem_rdata;
      // A new HI issue wins over the LO return that closes the previous one.
      if (r_st == ST_HI && w_credit) r_inflight <= 1'b1;
      else if (w_push)               r_inflight <= 1'b0;
    end
  end

  mcu0_ibuf #(
    .EW   (2*W),
    .DEPTH(DEPTH)
  ) u_ibuf (
    .i_clk      (i_clock),
    .i_rst      (i_reset),
    .i_flush    (i_redirect),
    .i_push     (w_push),
    .i_push_data({r_hi, i_mem_rdata, r_tag_pc}),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_valid    (w_valid),
    .o_count    (w_count)
  );

  assign o_ir       = w_head[2*W-1:W];
  assign o_ir_pc    = w_head[W-1:0];
  assign o_ir_valid = w_valid;
endmodule

// File: tb/tb_mcu0_fetch.sv
// Bench for mcu0_fetch: byte memory model, in-order expected-pc stream model,
// directed timing cases and a randomized ready/redirect/reset phase.
module tb_mcu0_fetch;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        i_reset, i_ir_ready, i_redirect;
  logic [15:0] i_redirect_pc;
  logic        o_mem_rd, o_ir_valid;
  logic [15:0] o_mem_addr, o_ir, o_ir_pc;
  logic [7:0]  i_mem_rdata;

  always #5 clk = ~clk;

  mcu0_fetch #(.W(16), .DEPTH(2), .RESET_PC(RPC)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .o_mem_rd     (o_mem_rd),
    .o_mem_addr   (o_mem_addr),
    .i_mem_rdata  (i_mem_rdata),
    .o_ir         (o_ir),
    .o_ir_pc      (o_ir_pc),
    .o_ir_valid   (o_ir_valid),
    .i_ir_ready   (i_ir_ready),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc)
  );

  logic [7:0] mem [0:65535];
  // Garbage on idle cycles so untagged data is never mistaken for a byte.
  always @(posedge clk) i_mem_rdata <= o_mem_rd ? mem[o_mem_addr] : 8'($urandom);

  int          n_chk = 0, n_err = 0;
  logic [15:0] exp_pc;
  logic [15:0] acc_pc [$];
  logic        s_valid, s_rd;
  logic [15:0] s_ir, s_pc, s_addr;
  int          nrd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic [15:0] pc);
    logic [15:0] p1;
    p1 = pc + 16'd1;
    return {mem[pc], mem[p1]};
  endfunction

  // One cycle: drive, sample mid-cycle, update the expected stream.
  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [15:0] rpc);
    i_reset = rst; i_ir_ready = rdy; i_redirect = redir; i_redirect_pc = rpc;
    @(negedge clk);
    s_valid = o_ir_valid; s_ir = o_ir; s_pc = o_ir_pc; s_rd = o_mem_rd; s_addr = o_mem_addr;
    if (rst) begin
      exp_pc = RPC;
    end else begin
      if (o_ir_valid && rdy) begin
        chk("ir_pc", o_ir_pc, exp_pc);
        chk("ir", o_ir, word(exp_pc));
        acc_pc.push_back(o_ir_pc);
        exp_pc = exp_pc + 16'd2;
      end
      if (redir) exp_pc = rpc & 16'hFFFE;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    i_reset = 1'b1; i_ir_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[0] = 8'h01; mem[1] = 8'h0A; mem[2] = 8'h10; mem[3] = 8'h0C;

    // reset state and first-fetch timing
    do_reset();
    chk("rst_vld", s_valid, 0); chk("rst_rd", s_rd, 0); chk("rst_addr", s_addr, 0);
    chk("rst_ir", s_ir, 0); chk("rst_pc", s_pc, 0);
    step(0, 1, 0, 0); chk("c0_rd", s_rd, 1); chk("c0_addr", s_addr, 16'h0000);
    step(0, 1, 0, 0); chk("c1_rd", s_rd, 1); chk("c1_addr", s_addr, 16'h0001);
    step(0, 1, 0, 0); chk("c2_vld", s_valid, 0);
    step(0, 1, 0, 0); chk("c3_vld", s_valid, 1); chk("c3_ir", s_ir, 16'h010A); chk("c3_pc", s_pc, 0);
    step(0, 1, 0, 0); chk("c4_vld", s_valid, 0);
    step(0, 1, 0, 0); chk("c5_vld", s_valid, 1); chk("c5_ir", s_ir, 16'h100C); chk("c5_pc", s_pc, 2);

    // consumer stalled: exactly two instructions fetched, then released
    do_reset();
    nrd = 0;
    repeat (10) begin step(0, 0, 0, 0); nrd += int'(s_rd); end
    chk("stall_reads", nrd, 4); chk("stall_rd", s_rd, 0);
    chk("stall_vld", s_valid, 1); chk("stall_pc", s_pc, 0);
    acc_pc.delete();
    repeat (8) step(0, 1, 0, 0);
    chk("rel_n", acc_pc.size(), 4);
    if (acc_pc.size() >= 2) begin chk("rel_first", acc_pc[0], 0); chk("rel_second", acc_pc[1], 2); end

    // redirect in cycle 6 to an odd address
    do_reset();
    repeat (6) step(0, 1, 0, 0);
    step(0, 1, 1, 16'h0011);
    step(0, 1, 0, 0); chk("r7_vld", s_valid, 0); chk("r7_rd", s_rd, 1); chk("r7_addr", s_addr, 16'h0010);
    step(0, 1, 0, 0); chk("r8_vld", s_valid, 0); chk("r8_addr", s_addr, 16'h0011);
    step(0, 1, 0, 0); chk("r9_vld", s_valid, 0);
    step(0, 1, 0, 0); chk("r10_vld", s_valid, 1); chk("r10_pc", s_pc, 16'h0010);
    repeat (6) step(0, 1, 0, 0);

    // redirect coinciding with a push and a pop
    do_reset();
    repeat (4) step(0, 0, 0, 0);
    acc_pc.delete();
    step(0, 1, 1, 16'h0100);
    chk("rpp_once", acc_pc.size(), 1);
    step(0, 0, 0, 0); chk("rpp_empty", s_valid, 0);
    repeat (6) step(0, 1, 0, 0);
    chk("rpp_n", acc_pc.size(), 3);
    if (acc_pc.size() >= 2) chk("rpp_next", acc_pc[1], 16'h0100);

    // address wrap
    do_reset();
    acc_pc.delete();
    step(0, 1, 1, 16'hFFFE);
    repeat (8) step(0, 1, 0, 0);
    chk("wrap_n", acc_pc.size(), 3);
    if (acc_pc.size() >= 2) begin chk("wrap_a", acc_pc[0], 16'hFFFE); chk("wrap_b", acc_pc[1], 16'h0000); end

    // reset in the LO cycle with a HI byte returning
    do_reset();
    step(0, 1, 1, 16'h0200);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("mrst_vld", s_valid, 0); chk("mrst_rd", s_rd, 0); chk("mrst_addr", s_addr, 0);
    chk("mrst_ir", s_ir, 0); chk("mrst_pc", s_pc, 0);
    acc_pc.delete();
    repeat (8) step(0, 1, 0, 0);
    chk("mrst_n", acc_pc.size(), 3);
    if (acc_pc.size() >= 1) chk("mrst_first", acc_pc[0], RPC);

    // randomized ready / redirect / reset against the stream model
    do_reset();
    acc_pc.delete();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), 16'($urandom));
    end
    chk("rand_progress", (acc_pc.size() > 300), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
